// File: rtl/hrm_mem_sequencer.sv
// HRM data-memory initiator: turns one read/write request (direct or indirect)
// into the ADDR/R/srcA/wAR/wM strobe sequence for MEMORY, returning read data as a pulse.
module hrm_mem_sequencer #(
  parameter int unsigned MEM_RD_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_ind,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] ADDR,
  output logic [7:0] R,
  output logic       srcA,
  output logic       wAR,
  output logic       wM,
  input  logic [7:0] M
);

  typedef enum logic [2:0] {
    IDLE,
    LDAR,
    WAIT1,
    LDIND,
    WAIT2,
    ACC,
    RSP
  } state_t;

  localparam bit         HAS_WAIT  = (MEM_RD_WAIT > 0);
  localparam logic [1:0] WAIT_LOAD = HAS_WAIT ? 2'(MEM_RD_WAIT - 1) : 2'd0;

  state_t     state, state_d;
  logic [1:0] cnt, cnt_d;
  logic       write_q, ind_q;
  logic [7:0] data_q;
  logic       accept;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE:  if (req_valid) state_d = LDAR;
      LDAR: begin
        if (ind_q) begin
          if (HAS_WAIT) begin
            state_d = WAIT1;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = LDIND;
          end
        end else if (write_q || !HAS_WAIT) begin
          state_d = ACC;
        end else begin
          state_d = WAIT2;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT1: begin
        if (cnt == 2'd0) state_d = LDIND;
        else             cnt_d   = cnt - 2'd1;
      end
      LDIND: begin
        if (write_q || !HAS_WAIT) begin
          state_d = ACC;
        end else begin
          state_d = WAIT2;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT2: begin
        if (cnt == 2'd0) state_d = ACC;
        else             cnt_d   = cnt - 2'd1;
      end
      ACC:     state_d = write_q ? IDLE : RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are a pure decode of registered state, so reset clears them at once.
  assign req_ready = (state == IDLE);
  assign wAR       = (state == LDAR) || (state == LDIND);
  assign srcA      = (state == LDIND);
  assign wM        = (state == ACC) && write_q;
  assign rsp_valid = (state == RSP);

  // ADDR doubles as the latched request address: loaded on accept, so it is
  // already valid in LDAR and holds until the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      write_q  <= 1'b0;
      ind_q    <= 1'b0;
      data_q   <= '0;
      ADDR     <= '0;
      R        <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        ind_q   <= req_ind;
        ADDR    <= req_addr;
        data_q  <= req_data;
      end
      if ((state_d == ACC) && write_q) R <= data_q;
      if ((state == ACC) && !write_q) rsp_data <= M;
    end
  end

endmodule
